linked_list_walker: RTL

Parametrised linked-list search engine with its own node memory, a host write port and valid/ready request/response channels. It walks from a given head one node per cycle, matching either a node address or a node data value. It reports found/not-found, the matched node, the hop count, and a loop error when the walk exceeds the node count. It is the successor to the fixed single-shot address checker and serves as the lookup engine for list-based structures in the design.

---
 rtl/linked_list_walker.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/linked_list_walker.sv
// Linked-list search engine: owns a small node memory, walks a list from a
// requested head one node per cycle, and reports a match on node address or
// node payload, the hop count, or a loop error when the walk runs too long.
module linked_list_walker #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] wr_next,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_head,
    input  logic                  req_mode,
    input  logic [DATA_WIDTH-1:0] req_key,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_found,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] rsp_hops
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WALK = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // A walk that has taken DEPTH-1 hops without terminating must be cycling.
    localparam logic [ADDR_WIDTH-1:0] HOP_LIMIT = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] NULL_ADDR = '0;

    logic [DATA_WIDTH-1:0] node_data_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] node_next_mem [DEPTH];

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] curr;
    logic [ADDR_WIDTH-1:0] hops;
    logic                  mode;
    logic [DATA_WIDTH-1:0] key;

    logic [DATA_WIDTH-1:0] curr_data;
    logic [ADDR_WIDTH-1:0] curr_next;
    logic                  at_null;
    logic                  is_match;
    logic                  at_limit;
    logic                  req_fire;
    logic                  advance;

    // Node memory write port; contents survive reset and writes are taken in any state.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            node_data_mem[wr_addr] <= wr_data;
            node_next_mem[wr_addr] <= wr_next;
        end
    end

    // Asynchronous read of the current node and the per-hop termination tests.
    always_comb begin
        curr_data = node_data_mem[curr];
        curr_next = node_next_mem[curr];
        at_null   = (curr == NULL_ADDR);
        // NULL is excluded here so that key 0 in address mode can never hit it.
        is_match  = !at_null && (mode ? (curr_data == key)
                                      : (curr == key[ADDR_WIDTH-1:0]));
        at_limit  = (hops == HOP_LIMIT);
    end

    assign req_ready = rst && (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign req_fire  = req_valid && req_ready;
    assign advance   = (state == S_WALK) && !at_null && !is_match && !at_limit;

    // Control FSM and response registers; response fields change only on entry to RESP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            rsp_found <= 1'b0;
            rsp_error <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
            rsp_hops  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        state <= S_WALK;
                    end
                end
                S_WALK: begin
                    if (at_null) begin
                        state     <= S_RESP;
                        rsp_found <= 1'b0;
                        rsp_error <= 1'b0;
                        rsp_addr  <= '0;
                        rsp_data  <= '0;
                        rsp_hops  <= hops;
                    end else if (is_match) begin
                        state     <= S_RESP;
                        rsp_found <= 1'b1;
                        rsp_error <= 1'b0;
                        rsp_addr  <= curr;
                        rsp_data  <= curr_data;
                        rsp_hops  <= hops;
                    end else if (at_limit) begin
                        state     <= S_RESP;
                        rsp_found <= 1'b0;
                        rsp_error <= 1'b1;
                        rsp_addr  <= '0;
                        rsp_data  <= '0;
                        rsp_hops  <= hops;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Walk datapath: latch the request, then follow next pointers while no rule terminates.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            curr <= req_head;
            mode <= req_mode;
            key  <= req_key;
            hops <= '0;
        end else if (advance) begin
            curr <= curr_next;
            hops <= hops + 1'b1;
        end
    end

endmodule
